serial_op_sequencer: RTL and testbench
======================================

# serial_op_sequencer

Control FSM for the bit-serial ALU datapath. It accepts one operation per handshake and sequences exactly WIDTH bit-cycles of LSB-first shifting. It tracks the bit position with a bit counter, and owns the inter-bit carry register and the zero/carry flag accumulation. It sits between the instruction decode stage and the serial operand/result shift registers, driving their shift enables and the ALU slice's opcode and carry-in.

## Interface
Parameters:
- WIDTH, default 8: bits per operation; legal values are powers of two, 2 to 32.
- CW, default $clog2(WIDTH): width of bit_idx.

Ports:
- clk, in, 1: clock.
- rstn, in, 1: synchronous, active-low reset.
- op_valid, in, 1: decode presents an operation.
- op_ready, out, 1: sequencer can accept; high only in IDLE.
- opcode, in, 3: ADD=000, SUB=001, AND=010, OR=011, XOR=100, CMP=101; 110 and 111 are illegal.
- cout, in, 1: carry-out of the ALU bit slice for the current bit.
- res_bit, in, 1: result bit of the ALU bit slice for the current bit.
- alu_op, out, 3: latched opcode driven to the ALU slice.
- carry_q, out, 1: carry-in to the ALU slice.
- shift_en, out, 1: operand shift registers advance one bit.
- wb_en, out, 1: result shift register captures res_bit.
- bit_idx, out, CW: current bit position, 0 = LSB.
- first_bit, out, 1: high when bit_idx==0 during EXEC.
- last_bit, out, 1: high when bit_idx==WIDTH-1 during EXEC.
- done, out, 1: one-cycle completion pulse.
- illegal, out, 1: one-cycle pulse when an illegal opcode is accepted.
- flag_z, out, 1: zero flag, valid from the cycle after done.
- flag_c, out, 1: carry flag, valid from the cycle after done.

## Operation
- States: IDLE, EXEC, DONE. Two-bit encoding.
- IDLE:
  - op_ready=1.
  - On op_valid with a legal opcode: latch opcode into alu_op, clear the counter, set carry_q (1 for SUB/CMP, 0 otherwise), set z_acc=1, go to EXEC.
  - On op_valid with an illegal opcode: pulse illegal, no shifting, flags unchanged, stay in IDLE.
- EXEC:
  - shift_en=1 every cycle.
  - wb_en=shift_en except for CMP, where wb_en=0.
  - Counter increments each cycle.
  - carry_q <= cout for ADD/SUB/CMP; carry_q held 0 for AND/OR/XOR.
  - z_acc <= z_acc & ~res_bit.
  - On the last_bit cycle go to DONE.
- DONE:
  - done=1, shift_en=0, wb_en=0.
  - flag_z <= z_acc.
  - flag_c <= carry_q for arithmetic ops, 0 for logical ops.
  - Go to IDLE.
- op_valid is ignored outside IDLE. Decode must hold op_valid and opcode stable until op_ready is seen.
- Flags hold their value until the next DONE. An illegal op does not alter them.
- Counter arithmetic is modulo WIDTH. The wrap from WIDTH-1 to 0 coincides with leaving EXEC; the counter is cleared on accept regardless.

## Timing
- Accept in cycle T means op_valid&&op_ready are both high at the edge ending cycle T.
- EXEC occupies cycles T+1 to T+WIDTH:
  - bit_idx = 0..WIDTH-1.
  - first_bit at T+1, last_bit at T+WIDTH.
- done is high at T+WIDTH+1. Flags are updated at the edge ending that cycle.
- op_ready is high again at T+WIDTH+2. Throughput is one op per WIDTH+2 cycles.
- An illegal op pulses illegal in cycle T+1; op_ready stays high.
- Reset values (any time rstn=0, including mid-EXEC):
  - State: IDLE, counter 0.
  - Outputs: op_ready=1, alu_op=000, carry_q=0, z_acc=1, flag_z=0, flag_c=0.
  - Pulses and enables: shift_en, wb_en, done, illegal, first_bit, last_bit all 0.
  - An in-flight op is abandoned, with no done pulse.
- All outputs are registered or decoded from state and counter only. There is no combinational path from op_valid/cout/res_bit to any output except op_ready, which is state-only.

## Structure
- Shared package serial_pkg holds:
  - opcode localparams (OP_ADD..OP_CMP);
  - state encodings (S_IDLE, S_EXEC, S_DONE);
  - the default WIDTH.
- One sub-module, bit_counter: parameterized width with inputs en and clr and output done at WIDTH-1. Instantiate it with en=(state==EXEC) and clr=accept.
- Flag, carry and z_acc registers live in the top level.

## Test plan
- ADD, WIDTH=8, cout=1 on bit 3 only, res_bit all 0: shift_en high for exactly 8 cycles; carry_q=1 only on bit 4; done at T+9; flag_z=1, flag_c=0.
- SUB: carry_q=1 at first_bit; cout=1 on all bits, res_bit=1 on bit 7 -> flag_c=1, flag_z=0.
- CMP, opcode 101: wb_en stays 0 for all 8 EXEC cycles while shift_en=1; flags update normally.
- Opcode 111 presented: illegal pulses at T+1; no shift_en; flags keep their prior values; op_ready stays 1.
- rstn low during bit_idx=4 of an ADD: next cycle state is IDLE, all reset values hold, no done pulse; a fresh op then completes normally.
- op_valid held high with back-to-back XOR ops: accepts are 10 cycles apart; bit_idx restarts at 0; flag_c=0 after each.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial ALU control path: opcodes, FSM states
// and opcode classification helpers.
package serial_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_CMP = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_DONE = 2'b10
    } state_t;

    function automatic logic is_legal(input logic [2:0] op);
        return (op <= OP_CMP);
    endfunction

    // ADD, SUB and CMP propagate a carry between bits; the logical ops do not.
    function automatic logic is_arith(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_CMP);
    endfunction

    function automatic logic needs_carry_in(input logic [2:0] op);
        return (op == OP_SUB) || (op == OP_CMP);
    endfunction

endpackage

// File: rtl/serial_op_sequencer_bit_counter.sv
// Modulo-WIDTH bit position counter with synchronous clear and terminal flag.
module bit_counter #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          en,
    input  logic          clr,
    output logic [CW-1:0] count,
    output logic          done
);

    // WIDTH is a power of two, so natural CW-bit overflow gives the modulo wrap.
    always_ff @(posedge clk) begin
        if (!rstn || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign done = (count == CW'(WIDTH - 1));

endmodule

// File: rtl/serial_op_sequencer.sv
// Control FSM for the bit-serial ALU: accepts one op, sequences WIDTH LSB-first
// bit cycles, and accumulates the carry and zero flags.
module serial_op_sequencer
    import serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          op_valid,
    output logic          op_ready,
    input  logic [2:0]    opcode,
    input  logic          cout,
    input  logic          res_bit,
    output logic [2:0]    alu_op,
    output logic          carry_q,
    output logic          shift_en,
    output logic          wb_en,
    output logic [CW-1:0] bit_idx,
    output logic          first_bit,
    output logic          last_bit,
    output logic          done,
    output logic          illegal,
    output logic          flag_z,
    output logic          flag_c
);

    state_t state;
    state_t state_next;

    logic accept;
    logic reject;
    logic cnt_last;
    logic z_acc;

    assign accept = (state == S_IDLE) && op_valid && is_legal(opcode);
    assign reject = (state == S_IDLE) && op_valid && !is_legal(opcode);

    bit_counter #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_bit_counter (
        .clk   (clk),
        .rstn  (rstn),
        .en    (state == S_EXEC),
        .clr   (accept),
        .count (bit_idx),
        .done  (cnt_last)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (accept) state_next = S_EXEC;
            S_EXEC:  if (cnt_last) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        op_ready  = 1'b0;
        shift_en  = 1'b0;
        wb_en     = 1'b0;
        first_bit = 1'b0;
        last_bit  = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: op_ready = 1'b1;
            S_EXEC: begin
                shift_en  = 1'b1;
                wb_en     = (alu_op != OP_CMP);
                first_bit = (bit_idx == '0);
                last_bit  = cnt_last;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Opcode latch, inter-bit carry and zero accumulation.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            alu_op  <= OP_ADD;
            carry_q <= 1'b0;
            z_acc   <= 1'b1;
        end else if (accept) begin
            alu_op  <= opcode;
            carry_q <= needs_carry_in(opcode);
            z_acc   <= 1'b1;
        end else if (state == S_EXEC) begin
            carry_q <= is_arith(alu_op) ? cout : 1'b0;
            z_acc   <= z_acc & ~res_bit;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            flag_z  <= 1'b0;
            flag_c  <= 1'b0;
            illegal <= 1'b0;
        end else begin
            illegal <= reject;
            if (state == S_DONE) begin
                flag_z <= z_acc;
                flag_c <= is_arith(alu_op) ? carry_q : 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serial_op_sequencer.sv
// Directed self-checking bench for serial_op_sequencer at WIDTH=8; expected
// carry/flag values come from hand-computed patterns.
module tb_serial_op_sequencer;
    import serial_pkg::*;

    localparam int WIDTH = 8;
    localparam int CW    = 3;

    logic          clk = 1'b0;
    logic          rstn;
    logic          op_valid;
    logic          op_ready;
    logic [2:0]    opcode;
    logic          cout;
    logic          res_bit;
    logic [2:0]    alu_op;
    logic          carry_q;
    logic          shift_en;
    logic          wb_en;
    logic [CW-1:0] bit_idx;
    logic          first_bit;
    logic          last_bit;
    logic          done;
    logic          illegal;
    logic          flag_z;
    logic          flag_c;

    int errors = 0;
    int checks = 0;

    serial_op_sequencer #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .opcode    (opcode),
        .cout      (cout),
        .res_bit   (res_bit),
        .alu_op    (alu_op),
        .carry_q   (carry_q),
        .shift_en  (shift_en),
        .wb_en     (wb_en),
        .bit_idx   (bit_idx),
        .first_bit (first_bit),
        .last_bit  (last_bit),
        .done      (done),
        .illegal   (illegal),
        .flag_z    (flag_z),
        .flag_c    (flag_c)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Every cycle step lands 1 time unit after the rising edge.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkIdleReset();
        checkOutput("rst_op_ready", 32'(op_ready), 32'd1);
        checkOutput("rst_alu_op", 32'(alu_op), 32'd0);
        checkOutput("rst_carry_q", 32'(carry_q), 32'd0);
        checkOutput("rst_flag_z", 32'(flag_z), 32'd0);
        checkOutput("rst_flag_c", 32'(flag_c), 32'd0);
        checkOutput("rst_shift_en", 32'(shift_en), 32'd0);
        checkOutput("rst_wb_en", 32'(wb_en), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_illegal", 32'(illegal), 32'd0);
        checkOutput("rst_first_last", 32'({first_bit, last_bit}), 32'd0);
        checkOutput("rst_bit_idx", 32'(bit_idx), 32'd0);
    endtask

    // Runs one full legal op from IDLE; cout_pat/res_pat give per-bit slice outputs.
    task automatic applyStimulus(input logic [2:0] op, input logic [7:0] cout_pat,
                                 input logic [7:0] res_pat, input logic exp_z,
                                 input logic exp_c);
        logic exp_carry;
        logic arith;
        arith = (op == OP_ADD) || (op == OP_SUB) || (op == OP_CMP);
        checkOutput("idle_ready", 32'(op_ready), 32'd1);
        op_valid = 1'b1;
        opcode   = op;
        nextCycle();
        op_valid = 1'b0;
        opcode   = 3'b000;
        for (int i = 0; i < WIDTH; i++) begin
            if (i == 0) exp_carry = (op == OP_SUB) || (op == OP_CMP);
            else        exp_carry = arith ? cout_pat[i-1] : 1'b0;
            checkOutput("exec_shift_en", 32'(shift_en), 32'd1);
            checkOutput("exec_wb_en", 32'(wb_en), 32'(op != OP_CMP));
            checkOutput("exec_bit_idx", 32'(bit_idx), 32'(i));
            checkOutput("exec_first", 32'(first_bit), 32'(i == 0));
            checkOutput("exec_last", 32'(last_bit), 32'(i == WIDTH - 1));
            checkOutput("exec_carry_q", 32'(carry_q), 32'(exp_carry));
            checkOutput("exec_alu_op", 32'(alu_op), 32'(op));
            checkOutput("exec_not_ready", 32'({op_ready, done}), 32'd0);
            cout    = cout_pat[i];
            res_bit = res_pat[i];
            nextCycle();
        end
        cout    = 1'b0;
        res_bit = 1'b0;
        checkOutput("done_pulse", 32'(done), 32'd1);
        checkOutput("done_shift_wb", 32'({shift_en, wb_en}), 32'd0);
        checkOutput("done_not_ready", 32'(op_ready), 32'd0);
        nextCycle();
        checkOutput("post_done_low", 32'(done), 32'd0);
        checkOutput("post_ready", 32'(op_ready), 32'd1);
        checkOutput("flag_z", 32'(flag_z), 32'(exp_z));
        checkOutput("flag_c", 32'(flag_c), 32'(exp_c));
    endtask

    initial begin
        int cyc;
        int last_acc;
        int n_acc;

        rstn     = 1'b0;
        op_valid = 1'b0;
        opcode   = 3'b000;
        cout     = 1'b0;
        res_bit  = 1'b0;
        repeat (3) nextCycle();
        checkIdleReset();
        rstn = 1'b1;
        nextCycle();

        // ADD: carry only out of bit 3, all-zero result.
        applyStimulus(OP_ADD, 8'b0000_1000, 8'h00, 1'b1, 1'b0);
        // SUB: carry out of every bit, MSB of result set.
        applyStimulus(OP_SUB, 8'hFF, 8'h80, 1'b0, 1'b1);

        // Illegal opcode leaves flags at z=0, c=1.
        op_valid = 1'b1;
        opcode   = 3'b111;
        nextCycle();
        op_valid = 1'b0;
        checkOutput("ill_pulse", 32'(illegal), 32'd1);
        checkOutput("ill_ready", 32'(op_ready), 32'd1);
        checkOutput("ill_no_shift", 32'(shift_en), 32'd0);
        nextCycle();
        checkOutput("ill_pulse_end", 32'(illegal), 32'd0);
        checkOutput("ill_no_shift2", 32'(shift_en), 32'd0);
        checkOutput("ill_flag_z", 32'(flag_z), 32'd0);
        checkOutput("ill_flag_c", 32'(flag_c), 32'd1);

        // CMP: no writeback, zero result, final carry set.
        applyStimulus(OP_CMP, 8'hFF, 8'h00, 1'b1, 1'b1);
        // OR with a nonzero result: logical ops force flag_c low.
        applyStimulus(OP_OR, 8'hFF, 8'h04, 1'b0, 1'b0);

        // Reset during bit 4 of an ADD abandons it.
        op_valid = 1'b1;
        opcode   = OP_ADD;
        nextCycle();
        op_valid = 1'b0;
        repeat (4) nextCycle();
        checkOutput("mid_bit_idx", 32'(bit_idx), 32'd4);
        rstn = 1'b0;
        nextCycle();
        checkIdleReset();
        nextCycle();
        checkOutput("mid_no_done", 32'(done), 32'd0);
        rstn = 1'b1;
        nextCycle();
        checkOutput("mid_rel_no_done", 32'(done), 32'd0);
        applyStimulus(OP_ADD, 8'b1000_0001, 8'h01, 1'b0, 1'b1);

        // Back-to-back XOR with op_valid held high.
        op_valid = 1'b1;
        opcode   = OP_XOR;
        cyc      = 0;
        last_acc = -100;
        n_acc    = 0;
        while (cyc < 32) begin
            if (cyc == last_acc + 1) begin
                checkOutput("b2b_bit_idx0", 32'(bit_idx), 32'd0);
                checkOutput("b2b_first", 32'(first_bit), 32'd1);
            end
            if (cyc == last_acc + WIDTH + 2) begin
                checkOutput("b2b_flag_c", 32'(flag_c), 32'd0);
                checkOutput("b2b_ready", 32'(op_ready), 32'd1);
            end
            if (op_ready) begin
                if (n_acc > 0) checkOutput("b2b_spacing", 32'(cyc - last_acc), 32'(WIDTH + 2));
                last_acc = cyc;
                n_acc++;
            end
            nextCycle();
            cyc++;
        end
        op_valid = 1'b0;
        checkOutput("b2b_accepts", 32'(n_acc), 32'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
